// File: rtl/alu_pkg.sv
// Opcode groups and op codes shared by the ALU datapath and its sub-modules.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SH_W  = 5;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;

    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_MOVE = 4'b1010;

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_ROTR = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0011;

    localparam logic [3:0] OP_EQ   = 4'b0011;
    localparam logic [3:0] OP_NEQ  = 4'b0001;
    localparam logic [3:0] OP_LT   = 4'b0101;
    localparam logic [3:0] OP_LEZ  = 4'b1101;
    localparam logic [3:0] OP_LTZ  = 4'b1011;
    localparam logic [3:0] OP_GTZ  = 4'b1111;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
interface mips_alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [5:0]       ALUFun;
    logic             Sign;
    logic [WIDTH-1:0] Z;
    logic             Zero;
    logic             Overflow;
    logic             Negative;

    modport master (output A, B, ALUFun, Sign, input Z, Zero, Overflow, Negative);
    modport slave  (input A, B, ALUFun, Sign, output Z, Zero, Overflow, Negative);
endinterface

// File: rtl/alu_addsub.sv
// Combinational A+B / A-B with zero, overflow and negative flag generation.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             negative_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_w;
    logic             carry_w;
    logic             ovf_s_w;

    assign b_eff   = sub_i ? ~b_i : b_i;
    assign sum_w   = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(sub_i);
    assign carry_w = sum_w[WIDTH];
    assign sum_o   = sum_w[WIDTH-1:0];

    // Signed overflow: same effective operand signs, result sign differs.
    assign ovf_s_w = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);

    assign zero_o     = (sum_w[WIDTH-1:0] == '0);
    assign overflow_o = sign_i ? ovf_s_w : (sub_i ? ~carry_w : carry_w);
    assign negative_o = sign_i ? (sum_w[WIDTH-1] ^ ovf_s_w) : (sub_i & ~carry_w);

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS-style ALU with a single output register stage.
// Define ALU_ROTATE_EN to enable rotate-right on ALUFun=10_0010.
module mips_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mips_alu_if.slave  bus
);

    logic [WIDTH-1:0] sum_w;
    logic             zero_w;
    logic             ovf_w;
    logic             neg_w;

    logic [SH_W-1:0]  sh_w;
    logic [WIDTH-1:0] logic_w;
    logic [WIDTH-1:0] shift_w;
    logic             cond_w;
    logic             a_zero_w;
    logic             a_neg_w;

    logic [WIDTH-1:0] z_d, z_q;
    logic             zero_q, ovf_q, neg_q;

    alu_addsub u_addsub (
        .a_i        (bus.A),
        .b_i        (bus.B),
        .sub_i      (bus.ALUFun[0]),
        .sign_i     (bus.Sign),
        .sum_o      (sum_w),
        .zero_o     (zero_w),
        .overflow_o (ovf_w),
        .negative_o (neg_w)
    );

    assign sh_w     = bus.A[SH_W-1:0];
    assign a_zero_w = (bus.A == '0);
    assign a_neg_w  = bus.Sign & bus.A[WIDTH-1];

`ifdef ALU_ROTATE_EN
    logic [2*WIDTH-1:0] rot_w;
    assign rot_w = {bus.B, bus.B} >> sh_w;
`endif

    always_comb begin
        logic_w = '0;
        case (bus.ALUFun[3:0])
            OP_AND:  logic_w = bus.A & bus.B;
            OP_OR:   logic_w = bus.A | bus.B;
            OP_XOR:  logic_w = bus.A ^ bus.B;
            OP_NOR:  logic_w = ~(bus.A | bus.B);
            OP_MOVE: logic_w = bus.A;
            default: logic_w = '0;
        endcase
    end

    always_comb begin
        shift_w = '0;
        case (bus.ALUFun[3:0])
            OP_SLL:  shift_w = bus.B << sh_w;
            OP_SRL:  shift_w = bus.B >> sh_w;
            OP_SRA:  shift_w = WIDTH'($signed(bus.B) >>> sh_w);
`ifdef ALU_ROTATE_EN
            OP_ROTR: shift_w = rot_w[WIDTH-1:0];
`endif
            default: shift_w = '0;
        endcase
    end

    // Compare condition is chosen by ALUFun[3:1]; the adder is always subtracting here.
    always_comb begin
        cond_w = 1'b0;
        case (bus.ALUFun[3:1])
            OP_EQ[3:1]:  cond_w = zero_w;
            OP_NEQ[3:1]: cond_w = ~zero_w;
            OP_LT[3:1]:  cond_w = neg_w;
            OP_LEZ[3:1]: cond_w = a_zero_w | a_neg_w;
            OP_LTZ[3:1]: cond_w = a_neg_w;
            OP_GTZ[3:1]: cond_w = ~a_zero_w & ~a_neg_w;
            default:     cond_w = 1'b0;
        endcase
    end

    always_comb begin
        z_d = '0;
        case (bus.ALUFun[5:4])
            GRP_ARITH: z_d = sum_w;
            GRP_LOGIC: z_d = logic_w;
            GRP_SHIFT: z_d = shift_w;
            GRP_CMP:   z_d = {(WIDTH-1)'(0), cond_w};
            default:   z_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            z_q    <= z_d;
            zero_q <= zero_w;
            ovf_q  <= ovf_w;
            neg_q  <= neg_w;
        end
    end

    assign bus.Z        = z_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;
    assign bus.Negative = neg_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: literal directed cases plus random ops against an arithmetic model.
module tb_mips_alu;

    typedef struct {
        logic [31:0] z;
        logic        zero;
        logic        ov;
        logic        neg;
    } res_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    res_t exp_r;

    always #5 clk = ~clk;

    mips_alu_if bus ();

    mips_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: exact integer arithmetic interpreted by the ALU's rules.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] f, input logic s);
        res_t        r;
        longint      ua, ub, sa, sb, ex_u, ex_s;
        logic [31:0] s32;
        logic [4:0]  sh;
        logic        cond;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ex_u = f[0] ? ua - ub : ua + ub;
        ex_s = f[0] ? sa - sb : sa + sb;
        s32  = 32'(ex_u);
        sh   = a[4:0];
        r.zero = (s32 == 32'h0);
        if (s) begin
            r.ov  = (ex_s > SMAX) || (ex_s < SMIN);
            r.neg = (ex_s < 0);
        end else begin
            r.ov  = (ex_u < 0) || (ex_u > UMAX);
            r.neg = (ex_u < 0);
        end
        r.z  = 32'h0;
        cond = 1'b0;
        case (f[5:4])
            2'd0: r.z = s32;
            2'd1: case (f[3:0])
                4'd8:    r.z = a & b;
                4'd14:   r.z = a | b;
                4'd6:    r.z = a ^ b;
                4'd1:    r.z = ~(a | b);
                4'd10:   r.z = a;
                default: r.z = 32'h0;
            endcase
            2'd2: case (f[3:0])
                4'd0:    r.z = b << sh;
                4'd1:    r.z = b >> sh;
                4'd3:    r.z = 32'(sb >>> sh);
`ifdef ALU_ROTATE_EN
                4'd2: begin
                    r.z = b;
                    for (int i = 0; i < int'(sh); i++) r.z = {r.z[0], r.z[31:1]};
                end
`endif
                default: r.z = 32'h0;
            endcase
            default: begin
                case (f[3:1])
                    3'd1:    cond = (a == b);
                    3'd0:    cond = (a != b);
                    3'd2:    cond = s ? (sa < sb) : (ua < ub);
                    3'd6:    cond = (a == 0) || (s && sa < 0);
                    3'd5:    cond = s && (sa < 0);
                    3'd7:    cond = (a != 0) && !(s && sa < 0);
                    default: cond = 1'b0;
                endcase
                r.z = {31'h0, cond};
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected outputs, registered exactly one clock after the inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_r <= '{32'h0, 1'b0, 1'b0, 1'b0};
        else       exp_r <= model(bus.A, bus.B, bus.ALUFun, bus.Sign);
    end

    always @(posedge clk) begin
        if (chk_en) begin
            #2;
            chk("model_Z",        bus.Z,               exp_r.z);
            chk("model_Zero",     32'(bus.Zero),       32'(exp_r.zero));
            chk("model_Overflow", 32'(bus.Overflow),   32'(exp_r.ov));
            chk("model_Negative", 32'(bus.Negative),   32'(exp_r.neg));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input logic s);
        bus.A      = a;
        bus.B      = b;
        bus.ALUFun = f;
        bus.Sign   = s;
    endtask

    // Directed op with literal expectations; a negative flag expectation means "not checked".
    task automatic dir(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic s, input logic [31:0] ez,
                       input int ezero, input int eov, input int eneg);
        @(negedge clk);
        drive(a, b, f, s);
        @(posedge clk);
        #3;
        chk({name, "_Z"}, bus.Z, ez);
        if (ezero >= 0) chk({name, "_Zero"},     32'(bus.Zero),     32'(ezero));
        if (eov   >= 0) chk({name, "_Overflow"}, 32'(bus.Overflow), 32'(eov));
        if (eneg  >= 0) chk({name, "_Negative"}, 32'(bus.Negative), 32'(eneg));
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        logic [3:0] lops [6];
        logic [3:0] sops [4];
        logic [1:0] g;
        logic [3:0] lo;
        lops = '{4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b1010, 4'b0000};
        sops = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        g    = 2'($urandom_range(0, 3));
        lo   = 4'($urandom);
        if ($urandom_range(0, 7) != 0) begin
            case (g)
                2'd0:    lo = {3'b000, 1'($urandom)};
                2'd1:    lo = lops[$urandom_range(0, 5)];
                2'd2:    lo = sops[$urandom_range(0, 3)];
                default: lo = lo;
            endcase
        end
        if (g == 2'd3) lo[0] = 1'b1;
        return {g, lo};
    endfunction

    initial begin
        res_t        mr;
        logic [31:0] ra;
        drive(32'h0, 32'h0, 6'h0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("reset_Z",        bus.Z,             32'h0);
        chk("reset_Zero",     32'(bus.Zero),     32'h0);
        chk("reset_Overflow", 32'(bus.Overflow), 32'h0);
        chk("reset_Negative", 32'(bus.Negative), 32'h0);

        mr = model(32'd5, 32'd33, 6'b00_0000, 1'b0);
        chk("pin_model_add", mr.z, 32'd38);
        mr = model(32'd5, 32'd10, 6'b00_0001, 1'b1);
        chk("pin_model_sub_neg", 32'({mr.z == 32'hFFFF_FFFB, mr.neg, mr.ov}), 32'b110);
        mr = model(32'h0000_0008, 32'hFFFF_0000, 6'b10_0011, 1'b0);
        chk("pin_model_sra", mr.z, 32'hFFFF_FF00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        dir("add_5_33",      32'd5,          32'd33,         6'b00_0000, 1'b0, 32'd38,         0,  0, -1);
        dir("add_s_wrap0",   32'h7FFF_FFFF,  32'h8000_0001,  6'b00_0000, 1'b1, 32'h0,          1,  0, -1);
        dir("add_u_carry",   32'hFFFF_FFFF,  32'd2,          6'b00_0000, 1'b0, 32'd1,         -1,  1, -1);
        dir("sub_u_borrow",  32'd5,          32'd10,         6'b00_0001, 1'b0, 32'hFFFF_FFFB, -1,  1,  1);
        dir("sub_s_neg",     32'd5,          32'd10,         6'b00_0001, 1'b1, 32'hFFFF_FFFB, -1,  0,  1);
        dir("sub_equal",     32'd50,         32'd50,         6'b00_0001, 1'b0, 32'h0,          1, -1, -1);
        dir("add_s_ovf",     32'h7FFF_FFFF,  32'd1,          6'b00_0000, 1'b1, 32'h8000_0000, -1,  1,  0);
        dir("eq_1_2",        32'd1,          32'd2,          6'b11_0011, 1'b0, 32'd0,         -1, -1, -1);
        dir("eq_1_1",        32'd1,          32'd1,          6'b11_0011, 1'b0, 32'd1,         -1, -1, -1);
        dir("neq_1_2",       32'd1,          32'd2,          6'b11_0001, 1'b0, 32'd1,         -1, -1, -1);
        dir("lt_1_2",        32'd1,          32'd2,          6'b11_0101, 1'b1, 32'd1,         -1, -1, -1);
        dir("lt_u_neg1_2",   32'hFFFF_FFFF,  32'd2,          6'b11_0101, 1'b0, 32'd0,         -1, -1, -1);
        dir("lez_neg",       32'hFFFF_FFFF,  32'd0,          6'b11_1101, 1'b1, 32'd1,         -1, -1, -1);
        dir("gtz_neg",       32'hFFFF_FFFF,  32'd0,          6'b11_1111, 1'b1, 32'd0,         -1, -1, -1);
        dir("ltz_zero",      32'd0,          32'd0,          6'b11_1011, 1'b1, 32'd0,         -1, -1, -1);
        dir("ltz_u_neg",     32'hFFFF_FFFF,  32'd0,          6'b11_1011, 1'b0, 32'd0,         -1, -1, -1);
        dir("and_1_1",       32'd1,          32'd1,          6'b01_1000, 1'b0, 32'd1,         -1, -1, -1);
        dir("nor_0_0",       32'd0,          32'd0,          6'b01_0001, 1'b0, 32'hFFFF_FFFF, -1, -1, -1);
        dir("move_a",        32'h1234_5678,  32'hFFFF_0000,  6'b01_1010, 1'b0, 32'h1234_5678, -1, -1, -1);
        dir("logic_undef",   32'h1234_5678,  32'hFFFF_0000,  6'b01_0000, 1'b0, 32'h0,         -1, -1, -1);
        dir("sll_16",        32'd16,         32'h0000_FFFF,  6'b10_0000, 1'b0, 32'hFFFF_0000, -1, -1, -1);
        dir("srl_16",        32'd16,         32'hFFFF_0000,  6'b10_0001, 1'b0, 32'h0000_FFFF, -1, -1, -1);
        dir("sra_neg_8",     32'd8,          32'hFFFF_0000,  6'b10_0011, 1'b0, 32'hFFFF_FF00, -1, -1, -1);
        dir("sra_pos_8",     32'd8,          32'h00FF_0000,  6'b10_0011, 1'b0, 32'h0000_FF00, -1, -1, -1);
        dir("sll_hi_ignored",32'hFFFF_FFE0,  32'hABCD_0123,  6'b10_0000, 1'b0, 32'hABCD_0123, -1, -1, -1);
        dir("shift_undef",   32'd4,          32'hABCD_0123,  6'b10_0100, 1'b0, 32'h0,         -1, -1, -1);
`ifdef ALU_ROTATE_EN
        dir("rotr_8",        32'd8,          32'h1234_5678,  6'b10_0010, 1'b0, 32'h7812_3456, -1, -1, -1);
`else
        dir("rotr_off",      32'd8,          32'h1234_5678,  6'b10_0010, 1'b0, 32'h0,         -1, -1, -1);
`endif

        // Asynchronous reset in the middle of a cycle with a nonzero result held.
        dir("pre_reset",     32'd4,          32'h0000_00F0,  6'b10_0000, 1'b0, 32'h0000_0F00, -1, -1, -1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_Z",    bus.Z,             32'h0);
        chk("async_reset_Zero", 32'(bus.Zero),     32'h0);
        chk("async_reset_Ovf",  32'(bus.Overflow), 32'h0);
        chk("async_reset_Neg",  32'(bus.Negative), 32'h0);
        @(posedge clk);
        #1;
        chk("held_reset_Z", bus.Z, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0000_F0F0, 32'h0000_FF00, 6'b01_1000, 1'b0);
        @(posedge clk);
        #3;
        chk("post_reset_Z", bus.Z, 32'h0000_F000);

        repeat (3000) begin
            @(negedge clk);
            ra = rand_val();
            drive(ra, ($urandom_range(0, 5) == 0) ? ra : rand_val(), rand_op(), 1'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
